// File: rtl/module_switch_reader_pkg.sv
// -----------------------------------------------------------------------------
// pkg_entrada: shared types and constants for the switch reader.
//   estado_captura_t : capture FSM state encoding (ESPERA / SOSTENIDO)
//   DEBOUNCE_DEFAULT : default stable-cycle count (10 ms at 27 MHz)
//   N_SW             : number of board switches sampled
// -----------------------------------------------------------------------------
package pkg_entrada;

  typedef enum logic {
    ESPERA    = 1'b0,
    SOSTENIDO = 1'b1
  } estado_captura_t;

  localparam int DEBOUNCE_DEFAULT = 270000;
  localparam int N_SW             = 4;

endpackage

// File: rtl/module_switch_reader_if.sv
// -----------------------------------------------------------------------------
// module_switch_reader_if: output bundle of the switch reader.
//   binario    : last captured nibble
//   valido     : capture strobe
//   sw_estable : current debounced switch value, active-high
//   estado     : capture FSM state, exposed for observation
// Handshake: valido is a pure one-cycle strobe with no ready/back-pressure;
// binario is valid (and newly loaded) in exactly the cycle valido is high and
// holds that value until the next strobe. The consumer must accept every strobe.
// Modports: master = switch reader (drives), slave = consumer (e.g. decoder).
// -----------------------------------------------------------------------------
interface module_switch_reader_if;
  import pkg_entrada::*;

  logic [N_SW-1:0] binario;
  logic            valido;
  logic [N_SW-1:0] sw_estable;
  estado_captura_t estado;

  modport master (output binario, output valido, output sw_estable, output estado);
  modport slave  (input  binario, input  valido, input  sw_estable, input  estado);

endinterface

// File: rtl/module_switch_reader_debounce.sv
// -----------------------------------------------------------------------------
// module_debounce: one-bit 2-flop synchronizer followed by a counter debouncer.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw_i      : raw asynchronous pad level
//   nivel_o    : accepted (debounced) level, registered; resets to 1 (released)
//   cambio_o   : high in the cycle whose closing edge flips nivel_o
// The accepted level follows a stable raw change after exactly
// 2 + DEBOUNCE_CYCLES clock edges (2 sync + DEBOUNCE_CYCLES counting).
// -----------------------------------------------------------------------------
module module_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic nivel_o,
  output logic cambio_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             nivel_q, nivel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cambio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      nivel_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      nivel_q <= nivel_d;
      cnt_q   <= cnt_d;
    end
  end

  // The flip happens on the edge where the counter already sits at the last
  // value and the synchronized level still disagrees.
  assign cambio = (sync2_q != nivel_q) && (cnt_q == CNT_LAST);

  always_comb begin
    nivel_d = nivel_q;
    cnt_d   = cnt_q;
    if (sync2_q == nivel_q) begin
      cnt_d = '0;
    end else if (cambio) begin
      nivel_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign nivel_o  = nivel_q;
  assign cambio_o = cambio;

endmodule

// File: rtl/module_switch_reader.sv
// -----------------------------------------------------------------------------
// module_switch_reader: samples four active-low switches and an active-low
// capture button, debounces them and, on each clean press, latches the switch
// pattern as a nibble with a one-cycle strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   sw_n[3:0]  : raw switches, active-low, asynchronous
//   btn_n      : raw capture button, active-low, asynchronous
//   bus        : master side of module_switch_reader_if
//                (binario, valido, sw_estable, estado)
// Optional build macro: MODULE_SWITCH_READER_AUTO_CAPTURE_EN
//   When defined, every change of sw_estable also triggers a capture one cycle
//   later; a coinciding button capture wins and the auto capture is deferred
//   by one more cycle.
// -----------------------------------------------------------------------------
module module_switch_reader
  import pkg_entrada::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SW-1:0]        sw_n,
  input  logic                   btn_n,
  module_switch_reader_if.master bus
);

  logic [N_SW-1:0] sw_nivel, sw_cambio;
  logic            btn_nivel, btn_cambio;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    module_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (sw_n[i]),
      .nivel_o  (sw_nivel[i]),
      .cambio_o (sw_cambio[i])
    );
  end

  module_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_btn (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    (btn_n),
    .nivel_o  (btn_nivel),
    .cambio_o (btn_cambio)
  );

  // Button events are taken at the flip edge itself, so a capture sees the
  // sw_estable value from before any switch flip landing on the same edge.
  logic btn_cae, btn_sube;
  assign btn_cae  = btn_cambio &  btn_nivel;
  assign btn_sube = btn_cambio & ~btn_nivel;

  // ---------------------------------------------------------------------------
  // Debounced switch value, active-high. On a flip the new accepted level is
  // the inverse of the old one, so the active-high value equals the old level.
  // ---------------------------------------------------------------------------
  logic [N_SW-1:0] sw_estable_q, sw_estable_d;

  always_comb begin
    sw_estable_d = sw_estable_q;
    for (int i = 0; i < N_SW; i++) begin
      if (sw_cambio[i]) sw_estable_d[i] = sw_nivel[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_estable_q <= '0;
    else        sw_estable_q <= sw_estable_d;
  end

  // ---------------------------------------------------------------------------
  // Capture FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  estado_captura_t estado_q, estado_d;
  logic            captura_btn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= ESPERA;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ESPERA:    if (btn_cae)  estado_d = SOSTENIDO;
      SOSTENIDO: if (btn_sube) estado_d = ESPERA;
      default:   estado_d = ESPERA;
    endcase
  end

  always_comb begin
    captura_btn = (estado_q == ESPERA) && btn_cae;
  end

  // ---------------------------------------------------------------------------
  // Captured nibble and strobe
  // ---------------------------------------------------------------------------
  logic [N_SW-1:0] binario_q, binario_d;
  logic            valido_q, valido_d;

`ifdef MODULE_SWITCH_READER_AUTO_CAPTURE_EN
  // pend_q: sw_estable changed on the previous edge (or a deferred auto
  // capture is still waiting behind a button capture).
  logic pend_q, pend_d;

  always_comb begin
    binario_d = binario_q;
    valido_d  = 1'b0;
    pend_d    = |sw_cambio;
    if (captura_btn) begin
      binario_d = sw_estable_q;
      valido_d  = 1'b1;
      if (pend_q) pend_d = 1'b1;
    end else if (pend_q) begin
      binario_d = sw_estable_q;
      valido_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end
`else
  always_comb begin
    binario_d = binario_q;
    valido_d  = 1'b0;
    if (captura_btn) begin
      binario_d = sw_estable_q;
      valido_d  = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binario_q <= '0;
      valido_q  <= 1'b0;
    end else begin
      binario_q <= binario_d;
      valido_q  <= valido_d;
    end
  end

  assign bus.binario    = binario_q;
  assign bus.valido     = valido_q;
  assign bus.sw_estable = sw_estable_q;
  assign bus.estado     = estado_q;

endmodule

// File: tb/tb_module_switch_reader.sv
// -----------------------------------------------------------------------------
// tb_module_switch_reader: directed self-checking bench, DEBOUNCE_CYCLES = 4.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after a
// rising edge or on the falling edge.
// -----------------------------------------------------------------------------
module tb_module_switch_reader;
  import pkg_entrada::*;

  localparam int DEB = 4;
  localparam int LAT = 2 + DEB;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_n;
  logic       btn_n;

  module_switch_reader_if bus ();

  module_switch_reader #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_n  (sw_n),
    .btn_n (btn_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- strobe monitor ----------------
  int   pulse_cnt = 0;
  int   dbl_cnt   = 0;
  logic prev_v    = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valido === 1'b1) begin
        pulse_cnt++;
        if (prev_v) dbl_cnt++;
      end
      prev_v = bus.valido;
    end else begin
      prev_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until valido is seen, 0 if the budget expires.
  task automatic wait_pulse(output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.valido === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  int k;
  logic [3:0] any_bin, any_sw;

  initial begin
    // ---------------- 1. reset ----------------
    rst_n = 1'b0;
    sw_n  = 4'b1010;
    btn_n = 1'b0;
    cycles(3);
    check_eq("rst_binario",    32'(bus.binario),    32'h0);
    check_eq("rst_valido",     32'(bus.valido),     32'h0);
    check_eq("rst_sw_estable", 32'(bus.sw_estable), 32'h0);
    check_eq("rst_estado",     32'(bus.estado),     32'(ESPERA));
    sw_n  = 4'b1111;
    btn_n = 1'b1;
    rst_n = 1'b1;
    pulse_cnt = 0;
    any_bin = '0;
    any_sw  = '0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      any_bin |= bus.binario;
      any_sw  |= bus.sw_estable;
    end
    check_eq("idle_binario",    32'(any_bin),   32'h0);
    check_eq("idle_sw_estable", 32'(any_sw),    32'h0);
    check_eq("idle_pulses",     32'(pulse_cnt), 32'h0);

    // ---------------- 2. basic capture ----------------
    sw_n = 4'b0101;
    cycles(10);
    check_eq("basic_sw_estable", 32'(bus.sw_estable), 32'ha);
    pulse_cnt = 0;
    btn_n = 1'b0;
    wait_pulse(k);
    check_eq("basic_latency", 32'(k),           32'(LAT));
    check_eq("basic_binario", 32'(bus.binario), 32'ha);
    cycles(10);
    check_eq("basic_one_pulse", 32'(pulse_cnt), 32'h1);
    btn_n = 1'b1;
    cycles(10);
    btn_n = 1'b0;
    wait_pulse(k);
    check_eq("second_latency", 32'(k),           32'(LAT));
    check_eq("second_binario", 32'(bus.binario), 32'ha);
    btn_n = 1'b1;
    cycles(10);

    // ---------------- 3. bounce rejection ----------------
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      btn_n = ~btn_n;
      cycles(2);
    end
    btn_n = 1'b1;
    cycles(10);
    for (int i = 0; i < 6; i++) begin
      sw_n[0] = ~sw_n[0];
      cycles(3);
    end
    sw_n[0] = 1'b1;
    cycles(10);
    check_eq("bounce_pulses",     32'(pulse_cnt),      32'h0);
    check_eq("bounce_sw_estable", 32'(bus.sw_estable), 32'ha);
    check_eq("bounce_estado",     32'(bus.estado),     32'(ESPERA));

`ifndef MODULE_SWITCH_READER_AUTO_CAPTURE_EN
    // ---------------- 4. hold without recapture ----------------
    sw_n = 4'b1111;
    cycles(10);
    pulse_cnt = 0;
    btn_n = 1'b0;
    cycles(10);
    sw_n = 4'b0000;
    cycles(90);
    check_eq("hold_pulses",     32'(pulse_cnt),      32'h1);
    check_eq("hold_binario",    32'(bus.binario),    32'h0);
    check_eq("hold_sw_estable", 32'(bus.sw_estable), 32'hf);
    btn_n = 1'b1;
    cycles(10);
`endif

    // ---------------- 5. simultaneous switch change and press ----------------
    sw_n = 4'b1010;
    cycles(10);
    sw_n  = 4'b0000;
    btn_n = 1'b0;
    wait_pulse(k);
    check_eq("simul_latency", 32'(k),           32'(LAT));
    check_eq("simul_binario", 32'(bus.binario), 32'h5);
    btn_n = 1'b1;
    cycles(10);
    btn_n = 1'b0;
    wait_pulse(k);
    check_eq("next_press_binario", 32'(bus.binario), 32'hf);

    // ---------------- 6. reset while held ----------------
    cycles(3);
    check_eq("held_estado", 32'(bus.estado), 32'(SOSTENIDO));
    rst_n = 1'b0;
    #1;
    check_eq("midrst_binario",    32'(bus.binario),    32'h0);
    check_eq("midrst_valido",     32'(bus.valido),     32'h0);
    check_eq("midrst_sw_estable", 32'(bus.sw_estable), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_pulse(k);
    // sw_estable flips on the same edge, so the capture sees the reset value 0
    check_eq("postrst_latency", 32'(k),           32'(LAT));
    check_eq("postrst_binario", 32'(bus.binario), 32'h0);
    btn_n = 1'b1;
    cycles(10);

    // ---------------- switch change with no press ----------------
    sw_n = 4'b1111;
    cycles(10);
    pulse_cnt = 0;
    sw_n = 4'b1100;
    cycles(12);
    check_eq("nopress_sw_estable", 32'(bus.sw_estable), 32'h3);
`ifdef MODULE_SWITCH_READER_AUTO_CAPTURE_EN
    check_eq("auto_pulses",  32'(pulse_cnt),   32'h1);
    check_eq("auto_binario", 32'(bus.binario), 32'h3);
`else
    check_eq("nopress_pulses",  32'(pulse_cnt),   32'h0);
    check_eq("nopress_binario", 32'(bus.binario), 32'h0);
    check_eq("no_double_valido", 32'(dbl_cnt),    32'h0);
`endif

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
